fir_out_window_stats: RTL and testbench
=======================================

// Module: fir_out_window_stats
// PURPOSE
//  Output stage directly downstream of the MAC FIR: takes the 16-bit signed filter result Yn
//  plus a per-sample strobe and rescales it to 8 bits (round + saturate) for DAC/LED use.
//  Tracks min, max and peak-to-peak of Yn over fixed windows of WIN_LEN samples.
//  Reports once per window so the filter's gain and ripple on the 50-sample stimulus period
//  can be checked on hardware.
// PARAMETERS
//  IN_W    16  width of Yn (signed)
//  OUT_W   8   width of rescaled output Yq (signed)
//  SHIFT   7   arithmetic right shift applied in rescale, >=1
//  WIN_LEN 50  samples per statistics window, >=2
// PORTS
//  clk        in   1        single clock, all flops rising-edge
//  Rst        in   1        reset, synchronous, active-high
//  Yn         in   IN_W     signed FIR output sample
//  Yn_valid   in   1        Yn is a new sample this cycle (tie high for one sample per clock)
//  Yq         out  OUT_W    signed rounded/saturated sample
//  Yq_valid   out  1        Yq updated this cycle
//  sat        out  1        current Yq was clipped
//  win_max    out  IN_W     signed max of Yn over last completed window
//  win_min    out  IN_W     signed min of Yn over last completed window
//  win_p2p    out  IN_W+1   unsigned win_max - win_min
//  win_valid  out  1        one-cycle pulse: win_* just updated
//  sat_cnt    out  8        clipped samples in last window (see CONFIGURATION)
// BEHAVIOUR
//  Reset: Yq=0, Yq_valid=0, sat=0, win_max=0, win_min=0, win_p2p=0, win_valid=0, sat_cnt=0,
//   sample counter=0, FSM=IDLE. Rst wins over Yn_valid in the same cycle.
//  Reset mid-window discards the partial window; no win_valid is produced for it.
//  Rescale (latency 1, registered):
//   - t = sext(Yn, IN_W+1) + 2^(SHIFT-1); r = t >>> SHIFT (round half up).
//   - If r > 2^(OUT_W-1)-1: Yq = max and sat = 1. If r < -2^(OUT_W-1): Yq = min and sat = 1.
//   - Else Yq = r and sat = 0.
//   - Yq, sat and Yq_valid update only when Yn_valid=1. Otherwise Yq and sat hold and Yq_valid=0.
//  Window FSM, states IDLE and ACC:
//   - IDLE: on Yn_valid, cur_max = cur_min = Yn, cnt = 1, go to ACC.
//   - ACC: on Yn_valid, cur_max/cur_min are updated by signed compare and cnt increments.
//   - ACC: when the sample arriving has cnt == WIN_LEN-1, that sample is included in the window.
//   - Window close: next cycle win_max/win_min/win_p2p/sat_cnt are loaded and win_valid = 1
//     for one cycle; the FSM returns to IDLE, so the next valid sample starts a new window.
//     The window's last sample and the next window's first sample may be on adjacent cycles;
//     no sample is lost.
//   - Gaps (Yn_valid=0) hold all state. win_* hold between pulses.
//  win_p2p is computed at IN_W+1 bits and never overflows (full scale: 65535).
//  Latency: sample to Yq is 1 cycle; last sample of a window to win_valid is 1 cycle.
// CONFIGURATION
//  Macro FIR_SAT_COUNT_EN.
//  Defined: per-window counter of samples with sat=1, saturating at 255, loaded into sat_cnt
//   at window close and cleared for the next window.
//  Undefined: no counter logic; sat_cnt is constant 0. All other behaviour is identical.
// STRUCTURE
//  Shared package fir_pkg: IN_W/OUT_W defaults, FSM state typedef {IDLE, ACC}, and a
//  sat_round function (rescale only).
//  One sub-module, fir_round_sat: the combinational rescale (t, r, clip, sat). Top-level
//  file holds the registers, FSM and counters.
// TESTING
//  1 Rescale, SHIFT=7: Yn=200->Yq=2,sat=0; Yn=16383->127,sat=1; Yn=-16384->-128,sat=0;
//    Yn=-32768->-128,sat=1; Yn=32767->127,sat=1 (no overflow in t).
//  2 WIN_LEN=4, contiguous Yn=5,-3,10,2 -> one cycle after the 4th sample: win_max=10,
//    win_min=-3, win_p2p=13, win_valid pulse of width 1.
//  3 Same samples with 3 idle cycles between each -> identical win_* values; win_valid one
//    cycle after the 4th valid sample; Yq_valid=0 on gap cycles.
//  4 Back-to-back windows, WIN_LEN=4: 1,2,3,4 then -7,0,0,0 -> second report max=0,min=-7,
//    p2p=7; first-window values do not leak into the second.
//  5 Rst asserted after 2 samples of a window, with Yn_valid=1 in the reset cycle -> all
//    outputs 0 next cycle; the next 4 samples form a complete window.
//  6 Built with FIR_SAT_COUNT_EN, WIN_LEN=4: Yn=32767,0,-32768,100 -> sat_cnt=2;
//    built without the macro -> sat_cnt=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage: default widths, window FSM states
// and the clip decision used by the rescaler.
package fir_pkg;

    localparam int FIR_IN_W      = 16;
    localparam int FIR_OUT_W     = 8;
    localparam int FIR_SAT_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } win_state_t;

    typedef struct packed {
        logic clip;
        logic low;
    } clip_t;

    // Decide whether a rounded value fits a signed out_w-bit result, and on which side it clips.
    function automatic clip_t sat_round(input logic signed [31:0] r_val, input int out_w);
        clip_t              res_s;
        logic signed [31:0] hi_s;
        logic signed [31:0] lo_s;
        hi_s = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo_s = -(32'sd1 <<< (out_w - 1));
        if (r_val > hi_s) begin
            res_s.clip = 1'b1;
            res_s.low  = 1'b0;
        end else if (r_val < lo_s) begin
            res_s.clip = 1'b1;
            res_s.low  = 1'b1;
        end else begin
            res_s.clip = 1'b0;
            res_s.low  = 1'b0;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational rescale of a signed FIR sample: round half up, arithmetic shift,
// then saturate to the signed output range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]  yn,
    output logic signed [OUT_W-1:0] yq,
    output logic                    sat
);

    // One guard bit keeps the rounding add from wrapping at full-scale positive input.
    localparam int T_W = IN_W + 1;
    localparam logic signed [T_W-1:0]   HALF_C = T_W'(2 ** (SHIFT - 1));
    localparam logic signed [OUT_W-1:0] MAX_C  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_C  = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [T_W-1:0] t_s;
    logic signed [T_W-1:0] r_s;
    clip_t                 clip_s;

    // Round, shift and clip the incoming sample.
    always_comb begin
        t_s    = {yn[IN_W-1], yn} + HALF_C;
        r_s    = t_s >>> SHIFT;
        clip_s = sat_round(32'(r_s), OUT_W);
        if (!clip_s.clip) begin
            yq = r_s[OUT_W-1:0];
        end else if (clip_s.low) begin
            yq = MIN_C;
        end else begin
            yq = MAX_C;
        end
        sat = clip_s.clip;
    end

endmodule

// File: rtl/fir_out_window_stats.sv
// FIR output stage: registered 8-bit rescale plus per-window min/max/peak-to-peak reporting.
// Optional build macro FIR_SAT_COUNT_EN adds a per-window count of clipped samples on sat_cnt.
module fir_out_window_stats
    import fir_pkg::*;
#(
    parameter int IN_W    = FIR_IN_W,
    parameter int OUT_W   = FIR_OUT_W,
    parameter int SHIFT   = 7,
    parameter int WIN_LEN = 50
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic signed [IN_W-1:0]  Yn,
    input  logic                    Yn_valid,
    output logic signed [OUT_W-1:0] Yq,
    output logic                    Yq_valid,
    output logic                    sat,
    output logic signed [IN_W-1:0]  win_max,
    output logic signed [IN_W-1:0]  win_min,
    output logic [IN_W:0]           win_p2p,
    output logic                    win_valid,
    output logic [FIR_SAT_CNT_W-1:0] sat_cnt
);

    localparam int CNT_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIN_LEN - 1);

    logic signed [OUT_W-1:0] yq_s;
    logic                    sat_s;

    win_state_t              state_r;
    win_state_t              state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_s;
    logic signed [IN_W-1:0]  cur_max_r;
    logic signed [IN_W-1:0]  cur_min_r;
    logic signed [IN_W-1:0]  max_s;
    logic signed [IN_W-1:0]  min_s;
    logic [IN_W:0]           p2p_s;
    logic                    close_s;

    fir_round_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .yn  (Yn),
        .yq  (yq_s),
        .sat (sat_s)
    );

    // Rescaled sample register; holds between valid samples.
    always_ff @(posedge clk) begin
        if (Rst) begin
            Yq       <= {OUT_W{1'b0}};
            sat      <= 1'b0;
            Yq_valid <= 1'b0;
        end else if (Yn_valid) begin
            Yq       <= yq_s;
            sat      <= sat_s;
            Yq_valid <= 1'b1;
        end else begin
            Yq_valid <= 1'b0;
        end
    end

    // Window FSM next state: the closing sample is folded into the extremes before reporting.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        max_s   = cur_max_r;
        min_s   = cur_min_r;
        close_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (Yn_valid) begin
                    state_s = ACC;
                    cnt_s   = ONE_C;
                    max_s   = Yn;
                    min_s   = Yn;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (Yn_valid) begin
                    max_s = (Yn > cur_max_r) ? Yn : cur_max_r;
                    min_s = (Yn < cur_min_r) ? Yn : cur_min_r;
                    if (cnt_r == LAST_C) begin
                        close_s = 1'b1;
                        state_s = IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + ONE_C;
                    end
                end else begin
                    state_s = ACC;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
        p2p_s = {max_s[IN_W-1], max_s} - {min_s[IN_W-1], min_s};
    end

    // Window state and report registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            cur_max_r <= {IN_W{1'b0}};
            cur_min_r <= {IN_W{1'b0}};
            win_max   <= {IN_W{1'b0}};
            win_min   <= {IN_W{1'b0}};
            win_p2p   <= {(IN_W+1){1'b0}};
            win_valid <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            cur_max_r <= max_s;
            cur_min_r <= min_s;
            win_valid <= close_s;
            if (close_s) begin
                win_max <= max_s;
                win_min <= min_s;
                win_p2p <= p2p_s;
            end else begin
                win_p2p <= win_p2p;
            end
        end
    end

`ifdef FIR_SAT_COUNT_EN
    logic [FIR_SAT_CNT_W-1:0] sat_acc_r;
    logic [FIR_SAT_CNT_W-1:0] sat_inc_s;

    // Saturating increment for the clipped-sample tally.
    always_comb begin
        if (sat_s && (sat_acc_r != {FIR_SAT_CNT_W{1'b1}})) begin
            sat_inc_s = sat_acc_r + {{(FIR_SAT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_inc_s = sat_acc_r;
        end
    end

    // Per-window clip tally, published and cleared when the window closes.
    always_ff @(posedge clk) begin
        if (Rst) begin
            sat_acc_r <= {FIR_SAT_CNT_W{1'b0}};
            sat_cnt   <= {FIR_SAT_CNT_W{1'b0}};
        end else if (Yn_valid) begin
            if (close_s) begin
                sat_cnt   <= sat_inc_s;
                sat_acc_r <= {FIR_SAT_CNT_W{1'b0}};
            end else begin
                sat_acc_r <= sat_inc_s;
            end
        end else begin
            sat_acc_r <= sat_acc_r;
        end
    end
`else
    assign sat_cnt = {FIR_SAT_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fir_out_window_stats.sv
// Scoreboard bench for fir_out_window_stats (WIN_LEN=4): directed cases followed by random traffic.
module tb_fir_out_window_stats;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT   = 7;
    localparam int WIN_LEN = 4;

    logic                    clk = 1'b0;
    logic                    Rst;
    logic signed [IN_W-1:0]  Yn;
    logic                    Yn_valid;
    logic signed [OUT_W-1:0] Yq;
    logic                    Yq_valid;
    logic                    sat;
    logic signed [IN_W-1:0]  win_max;
    logic signed [IN_W-1:0]  win_min;
    logic [IN_W:0]           win_p2p;
    logic                    win_valid;
    logic [7:0]              sat_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {int q; int s;} yq_exp_t;
    typedef struct {int mx; int mn; int p2p; int sc;} win_exp_t;

    yq_exp_t  yq_q[$];
    win_exp_t win_q[$];
    int       cur_win[$];
    int       cur_sat = 0;

    always #5 clk = ~clk;

    fir_out_window_stats #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .WIN_LEN (WIN_LEN)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .Yn        (Yn),
        .Yn_valid  (Yn_valid),
        .Yq        (Yq),
        .Yq_valid  (Yq_valid),
        .sat       (sat),
        .win_max   (win_max),
        .win_min   (win_min),
        .win_p2p   (win_p2p),
        .win_valid (win_valid),
        .sat_cnt   (sat_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rescale: floor((y + 2^(SHIFT-1)) / 2^SHIFT), then clip to signed OUT_W.
    function automatic yq_exp_t ref_rescale(input int y);
        yq_exp_t e;
        int t;
        int r;
        int div;
        int hi;
        int lo;
        div = 1 << SHIFT;
        hi  = (1 << (OUT_W - 1)) - 1;
        lo  = -(1 << (OUT_W - 1));
        t   = y + (div / 2);
        if (t >= 0) r = t / div;
        else        r = -((-t + div - 1) / div);
        if (r > hi)      begin e.q = hi; e.s = 1; end
        else if (r < lo) begin e.q = lo; e.s = 1; end
        else             begin e.q = r;  e.s = 0; end
        return e;
    endfunction

    // Apply one cycle of stimulus and advance the reference model for it.
    task automatic drive(input bit v, input int d, input bit r);
        yq_exp_t  e;
        win_exp_t w;
        Rst      = r;
        Yn_valid = v;
        Yn       = 16'(d);
        if (r) begin
            cur_win.delete();
            cur_sat = 0;
        end else if (v) begin
            e = ref_rescale(d);
            yq_q.push_back(e);
            cur_win.push_back(d);
            if (e.s == 1 && cur_sat < 255) cur_sat++;
            if (cur_win.size() == WIN_LEN) begin
                w.mx = cur_win[0];
                w.mn = cur_win[0];
                foreach (cur_win[i]) begin
                    if (cur_win[i] > w.mx) w.mx = cur_win[i];
                    if (cur_win[i] < w.mn) w.mn = cur_win[i];
                end
                w.p2p = w.mx - w.mn;
`ifdef FIR_SAT_COUNT_EN
                w.sc = cur_sat;
`else
                w.sc = 0;
`endif
                win_q.push_back(w);
                cur_win.delete();
                cur_sat = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_Yq"},        int'(Yq),        0);
        check({tag, "_Yq_valid"},  int'(Yq_valid),  0);
        check({tag, "_sat"},       int'(sat),       0);
        check({tag, "_win_max"},   int'(win_max),   0);
        check({tag, "_win_min"},   int'(win_min),   0);
        check({tag, "_win_p2p"},   int'(win_p2p),   0);
        check({tag, "_win_valid"}, int'(win_valid), 0);
        check({tag, "_sat_cnt"},   int'(sat_cnt),   0);
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        if (Yq_valid === 1'b1) begin
            if (yq_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL yq_unexpected: got Yq=%0d with no sample pending, expected none", Yq);
            end else begin
                yq_exp_t e;
                e = yq_q.pop_front();
                check("Yq",  int'(Yq),  e.q);
                check("sat", int'(sat), e.s);
            end
        end
        if (win_valid === 1'b1) begin
            if (win_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win_unexpected: got win_valid=1 with no window pending, expected 0");
            end else begin
                win_exp_t w;
                w = win_q.pop_front();
                check("win_max", int'(win_max), w.mx);
                check("win_min", int'(win_min), w.mn);
                check("win_p2p", int'(win_p2p), w.p2p);
                check("sat_cnt", int'(sat_cnt), w.sc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat_a[4] = '{5, -3, 10, 2};
        int pat_b[8] = '{1, 2, 3, 4, -7, 0, 0, 0};
        int pat_r[5] = '{200, 16383, -16384, -32768, 32767};
        int pat_s[4] = '{32767, 0, -32768, 100};

        Rst = 1'b1; Yn_valid = 1'b0; Yn = 16'sd0;
        drive(0, 0, 1);
        drive(1, 1234, 1);
        check_reset_state("reset");

        // Rescale corners, then reset with a valid sample pending.
        foreach (pat_r[i]) drive(1, pat_r[i], 0);
        drive(1, 999, 1);
        check_reset_state("reset_after_rescale");

        // Contiguous window, then the same window with 3-cycle gaps.
        foreach (pat_a[i]) drive(1, pat_a[i], 0);
        foreach (pat_a[i]) begin
            drive(1, pat_a[i], 0);
            repeat (3) drive(0, 16'h7abc, 0);
        end

        // Back-to-back windows.
        foreach (pat_b[i]) drive(1, pat_b[i], 0);

        // Reset two samples into a window; the next four form a full window.
        drive(1, 300, 0);
        drive(1, -300, 0);
        drive(1, 5000, 1);
        check_reset_state("reset_mid_window");
        foreach (pat_a[i]) drive(1, pat_a[i], 0);

        // Clip tally window.
        foreach (pat_s[i]) drive(1, pat_s[i], 0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 500; k++) begin
            bit r;
            bit v;
            int d;
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) d = int'($urandom_range(0, 65535)) - 32768;
            else                          d = int'($urandom_range(0, 600)) - 300;
            drive(v, d, r);
        end

        repeat (4) drive(0, 0, 0);
        check("yq_queue_drained",  yq_q.size(),  0);
        check("win_queue_drained", win_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
